// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// D-stage branch resolution controller. Recognises beq/bne/bgezal in D,
// stalls while operands are not yet forwarded, resolves the branch in the
// same cycle its operands are ready, then tracks the architectural delay
// slot. Sticky flags report a branch found in a delay slot and an operand
// wait that ran too long.
//
// Optional build macro: BRANCH_STAT_EN
//   defined   -> br_cnt / taken_cnt count resolves / taken resolves (wrap 2^32)
//   undefined -> br_cnt / taken_cnt tied to 0, no counter flops
//
// Ports
//   clk            in   sole clock, rising edge
//   reset          in   synchronous active-high reset
//   d_valid        in   D-stage instruction valid
//   d_op[4:0]      in   D-stage op code
//   d_pc[31:0]     in   D-stage instruction PC
//   d_imm16[15:0]  in   branch offset field (word offset)
//   rs_ready       in   rs operand available from forwarding
//   rt_ready       in   rt operand available from forwarding
//   freeze         in   downstream pipeline freeze
//   flush          in   exception/eret flush of D
//   cmp_cond       in   branch comparator result
//   cmp_op[4:0]    out  op presented to comparator (0 when idle)
//   d_stall        out  hold F/D, bubble E
//   br_taken       out  redirect NPC to br_target this cycle
//   br_target[31:0]out  taken-branch target
//   link_we        out  GPR31 link write enable (bgezal)
//   link_addr[31:0]out  link value (pc + 8)
//   dslot_err      out  sticky: branch seen in a delay slot
//   hazard_timeout out  sticky: operand wait reached 15 cycles
//   br_cnt[31:0]   out  resolved-branch count
//   taken_cnt[31:0]out  taken-branch count
//
// States
//   IDLE      | no branch outstanding, ready to resolve
//   WAIT_OPND | branch in D waiting for forwarded operands
//   DSLOT     | branch resolved, waiting for the delay-slot instruction
// -----------------------------------------------------------------------------
module branch_resolve_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_op,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        freeze,
  input  logic        flush,
  input  logic        cmp_cond,
  output logic [4:0]  cmp_op,
  output logic        d_stall,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        dslot_err,
  output logic        hazard_timeout,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
);

  localparam logic [4:0] beq_op    = 5'd1;
  localparam logic [4:0] bne_op    = 5'd2;
  localparam logic [4:0] bgezal_op = 5'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    DSLOT     = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       dslot_err_q, dslot_err_d;
  logic       hazard_q, hazard_d;

  logic is_bgezal;
  logic is_br;
  logic ready;
  logic res_state;
  logic stall_c;
  logic resolve_c;

  assign is_bgezal = (d_op == bgezal_op);
  assign is_br     = d_valid && ((d_op == beq_op) || (d_op == bne_op) || is_bgezal);
  // bgezal compares rs against zero, so rt is irrelevant for it.
  assign ready     = rs_ready && (rt_ready || is_bgezal);
  assign res_state = (state_q == IDLE) || (state_q == WAIT_OPND);

  // Stall is independent of freeze: a frozen pipe must still not let an
  // unready branch advance once the freeze lifts.
  assign stall_c   = res_state && is_br && !ready && !flush;
  assign resolve_c = res_state && is_br &&  ready && !freeze && !flush;

  assign cmp_op    = (is_br && (state_q != DSLOT)) ? d_op : 5'd0;
  assign d_stall   = stall_c && !reset;
  assign br_taken  = resolve_c && cmp_cond && !reset;
  assign link_we   = resolve_c && is_bgezal && !reset;

  assign br_target = d_pc + 32'd4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign link_addr = d_pc + 32'd8;

  assign dslot_err      = dslot_err_q;
  assign hazard_timeout = hazard_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dslot_err_d = dslot_err_q;
    hazard_d    = hazard_q;

    // A branch occupying the delay slot is never resolved; just flag it.
    if (!flush && (state_q == DSLOT) && is_br) begin
      dslot_err_d = 1'b1;
    end

    if (flush) begin
      state_d    = IDLE;
      wait_cnt_d = 4'd0;
    end else if (!freeze) begin
      case (state_q)
        IDLE, WAIT_OPND: begin
          if (stall_c) begin
            state_d = WAIT_OPND;
            // Saturate so the counter cannot wrap back below the threshold.
            if (wait_cnt_q != 4'd15) begin
              wait_cnt_d = wait_cnt_q + 4'd1;
            end
            if (wait_cnt_d == 4'd15) begin
              hazard_d = 1'b1;
            end
          end else if (resolve_c) begin
            state_d    = DSLOT;
            wait_cnt_d = 4'd0;
          end else begin
            state_d    = IDLE;
            wait_cnt_d = 4'd0;
          end
        end
        DSLOT: begin
          if (d_valid) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      dslot_err_q <= 1'b0;
      hazard_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dslot_err_q <= dslot_err_d;
      hazard_q    <= hazard_d;
    end
  end

`ifdef BRANCH_STAT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] taken_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else if (resolve_c) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (cmp_cond) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign br_cnt    = 32'd0;
  assign taken_cnt = 32'd0;
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port d_valid, input, 1: D-stage instruction valid.
REQ-004 SHALL have port d_op, input, 5: D-stage op code from the shared op-define header (beq_op, bne_op, bgezal_op are branches; all others non-branch).
REQ-005 SHALL have port d_pc, input, 32: D-stage instruction PC.
REQ-006 SHALL have port d_imm16, input, 16: branch offset field.
REQ-007 SHALL have port rs_ready / rt_ready, input, 1 each: forwarded operand valid from the hazard unit.
REQ-008 SHALL have port freeze, input, 1: downstream pipeline freeze (e.g. mult/div busy).
REQ-009 SHALL have port flush, input, 1: exception/eret flush of D stage.
REQ-010 SHALL have port cmp_cond, input, 1: result from the branch comparator.
REQ-011 SHALL have port cmp_op, output, 5: op presented to the comparator.
REQ-012 SHALL have port d_stall, output, 1: hold F/D and bubble E.
REQ-013 SHALL have port br_taken, output, 1: redirect NPC to br_target this cycle.
REQ-014 SHALL have port br_target, output, 32: taken-branch target.
REQ-015 SHALL have port link_we / link_addr, output, 1 / 32: GPR31 link write for bgezal.
REQ-016 SHALL have port dslot_err / hazard_timeout, output, 1 each: sticky error flags.
REQ-017 SHALL have port br_cnt / taken_cnt, output, 32 each: statistics counters.

Function
REQ-018 SHALL implement states IDLE, WAIT_OPND, DSLOT; is_br = d_valid && d_op in {beq_op, bne_op, bgezal_op}; ready = rs_ready && (rt_ready || d_op==bgezal_op).
REQ-019 SHALL drive cmp_op = d_op when is_br and state != DSLOT, else 0, combinationally.
REQ-020 SHALL treat IDLE/WAIT_OPND with is_br && !ready && !flush as a stall: d_stall=1, br_taken=0, next state WAIT_OPND.
REQ-021 SHALL resolve in the same cycle when in IDLE/WAIT_OPND with is_br && ready && !freeze && !flush: br_taken=cmp_cond, d_stall=0, next state DSLOT.
REQ-022 SHALL set br_target = d_pc + 4 + (sign_ext(d_imm16) << 2), modulo 2^32 (wrap allowed), computed combinationally.
REQ-023 SHALL drive, in a bgezal resolve cycle, link_we=1 and link_addr=d_pc+8 regardless of cmp_cond; link_we=0 otherwise.
REQ-024 SHALL hold state and counters and suppress br_taken and link_we while freeze=1; d_stall follows REQ-020.
REQ-025 SHALL leave DSLOT for IDLE on the first non-frozen cycle with d_valid=1 (delay slot consumed); it SHALL stay in DSLOT while freeze=1 or d_valid=0.
REQ-026 SHALL, when a branch sits in D during DSLOT, not stall and not resolve it, and SHALL set dslot_err (sticky).
REQ-027 SHALL, on flush, force next state IDLE, clear wait_cnt and deassert br_taken/link_we that cycle; flush overrides freeze and ready.
REQ-028 SHALL keep a 4-bit wait_cnt incrementing each WAIT_OPND stall cycle and clearing on leaving WAIT_OPND; reaching 15 sets hazard_timeout (sticky), with the stall continuing.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force state=IDLE, wait_cnt=0, dslot_err=0, hazard_timeout=0, br_cnt=0, taken_cnt=0, regardless of other inputs, including mid-WAIT_OPND or DSLOT.
REQ-030 SHALL, while reset is asserted, hold combinational outputs d_stall, br_taken and link_we at 0.

Configuration
REQ-031 SHALL compile the statistics logic only when macro BRANCH_STAT_EN is defined: br_cnt increments per resolve, taken_cnt per taken resolve, both wrapping at 2^32.
REQ-032 SHALL, without BRANCH_STAT_EN, keep the br_cnt/taken_cnt ports with constant 0 and no counter flops.

Verification
REQ-033 SHALL cover: beq, pc=0x3000, imm=0x0004, ready, cmp_cond=1 -> same cycle br_taken=1, br_target=0x3014, next state DSLOT.
REQ-034 SHALL cover: bne with rt_ready=0 for 3 cycles, then 1 with cmp_cond=0 -> d_stall=1 for 3 cycles, then br_taken=0 and d_stall=0.
REQ-035 SHALL cover: bgezal, pc=0x3100, imm=0xFFFF, cmp_cond=0 -> link_we=1, link_addr=0x3108, br_target=0x3100, br_taken=0.
REQ-036 SHALL cover: rs_ready held 0 for 16 cycles -> hazard_timeout=1 from the 15th stall cycle onward; flush then -> IDLE, d_stall=0 next cycle.
REQ-037 SHALL cover: beq in the delay slot after a taken branch -> dslot_err=1, no stall, br_taken=0; a reset mid-DSLOT -> IDLE, all flags 0.
REQ-038 SHALL cover, with BRANCH_STAT_EN: 5 resolves with 3 taken -> br_cnt=5, taken_cnt=3; without it, both remain 0.
